// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM states, PCSel encodings and default width.
package pc_seq_pkg;

    localparam int unsigned DefaultDataWidth = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StStalled = 2'd1,
        StHalted  = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SelInc       = 2'd0,
        SelBranch    = 2'd1,
        SelJump      = 2'd2,
        SelOverwrite = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_redirect_hold.sv
// One-entry redirect target buffer with valid flag, load, clear and an optional bypass that
// presents the incoming target combinationally while it is being loaded.
module pc_redirect_hold
    import pc_seq_pkg::*;
#(
    parameter int unsigned DataWidth = DefaultDataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic                 bypass_i,
    input  logic [DataWidth-1:0] target_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] target_o
);

    logic                 valid_d, valid_q;
    logic [DataWidth-1:0] target_d, target_q;

    // A load in the same cycle as a clear keeps the newer target.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (load_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q | (bypass_i & load_i);
    assign target_o = (bypass_i && load_i) ? target_i : target_q;

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC controller: RUN/STALLED/HALTED FSM with prioritised redirects.
// Defining PC_SEQ_REDIRECT_HOLD_EN buffers redirects that arrive during a stall.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned           DataWidth    = DefaultDataWidth,
    parameter logic [DataWidth-1:0]  ResetAddress = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 TakeBranch,
    input  logic                 TakeJump,
    input  logic                 PCOverwrite,
    input  logic                 Halt,
    input  logic                 Stall,
    input  logic [DataWidth-1:0] BranchTarget,
    input  logic [DataWidth-1:0] JumpTarget,
    input  logic [DataWidth-1:0] OverwriteAddress,
    output logic [DataWidth-1:0] PC,
    output logic [DataWidth-1:0] NextPC,
    output logic [1:0]           PCSel,
    output logic                 FetchValid,
    output logic                 Halted,
    output logic                 RedirectPending
);

    pc_state_e            state_d, state_q;
    logic [DataWidth-1:0] pc_d, pc_q;
    pc_sel_e              pc_sel;

    logic                 redir;
    logic [DataWidth-1:0] redir_target;
    pc_sel_e              redir_sel;

    logic                 hold_load, hold_clear;
    logic                 pend_valid;
    logic [DataWidth-1:0] pend_target;

    always_comb begin
        redir        = 1'b1;
        redir_target = '0;
        redir_sel    = SelInc;
        if (PCOverwrite) begin
            redir_target = OverwriteAddress;
            redir_sel    = SelOverwrite;
        end else if (TakeJump) begin
            redir_target = JumpTarget;
            redir_sel    = SelJump;
        end else if (TakeBranch) begin
            redir_target = BranchTarget;
            redir_sel    = SelBranch;
        end else begin
            redir = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_sel     = SelInc;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        unique case (state_q)
            StHalted: begin
                if (PCOverwrite) begin
                    pc_d    = OverwriteAddress;
                    pc_sel  = SelOverwrite;
                    state_d = StRun;
                end
            end
            StRun, StStalled: begin
                if (Stall) begin
                    state_d = StStalled;
`ifdef PC_SEQ_REDIRECT_HOLD_EN
                    // PC is frozen; PCSel still reports which redirect was captured.
                    pc_sel = redir_sel;
                    if (redir) begin
                        hold_load = 1'b1;
                    end else if (Halt) begin
                        state_d    = StHalted;
                        hold_clear = 1'b1;
                    end
`else
                    if (redir) begin
                        pc_d   = redir_target;
                        pc_sel = redir_sel;
                    end else if (Halt) begin
                        state_d = StHalted;
                    end
`endif
                end else if (redir) begin
                    pc_d       = redir_target;
                    pc_sel     = redir_sel;
                    state_d    = StRun;
                    hold_clear = 1'b1;
                end else if (pend_valid) begin
                    pc_d       = pend_target;
                    pc_sel     = SelOverwrite;
                    state_d    = StRun;
                    hold_clear = 1'b1;
                end else if (Halt) begin
                    state_d = StHalted;
                end else begin
                    pc_d    = pc_q + DataWidth'(1);
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (Reset) begin
            state_d    = StRun;
            pc_d       = ResetAddress;
            pc_sel     = SelInc;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StRun;
            pc_q    <= ResetAddress;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_SEQ_REDIRECT_HOLD_EN
    pc_redirect_hold #(
        .DataWidth(DataWidth)
    ) u_hold (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .bypass_i(1'b0),
        .target_i(redir_target),
        .valid_o (pend_valid),
        .target_o(pend_target)
    );
`else
    logic unused_hold;
    assign unused_hold = hold_load ^ hold_clear;
    assign pend_valid  = 1'b0;
    assign pend_target = '0;
`endif

    assign PC              = pc_q;
    assign NextPC          = pc_d;
    assign PCSel           = pc_sel;
    assign FetchValid      = !Reset && (state_q != StHalted) && !Stall;
    assign Halted          = (state_q == StHalted);
    assign RedirectPending = pend_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus against a model.
module tb_pc_sequencer;

`ifdef PC_SEQ_REDIRECT_HOLD_EN
    localparam bit Hold = 1'b1;
`else
    localparam bit Hold = 1'b0;
`endif

    logic        Clk, Reset, TakeBranch, TakeJump, PCOverwrite, Halt, Stall;
    logic [15:0] BranchTarget, JumpTarget, OverwriteAddress;
    logic [15:0] PC, NextPC;
    logic [1:0]  PCSel;
    logic        FetchValid, Halted, RedirectPending;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(
        .DataWidth   (16),
        .ResetAddress(16'h0000)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .TakeBranch      (TakeBranch),
        .TakeJump        (TakeJump),
        .PCOverwrite     (PCOverwrite),
        .Halt            (Halt),
        .Stall           (Stall),
        .BranchTarget    (BranchTarget),
        .JumpTarget      (JumpTarget),
        .OverwriteAddress(OverwriteAddress),
        .PC              (PC),
        .NextPC          (NextPC),
        .PCSel           (PCSel),
        .FetchValid      (FetchValid),
        .Halted          (Halted),
        .RedirectPending (RedirectPending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        TakeBranch = 0; TakeJump = 0; PCOverwrite = 0; Halt = 0; Stall = 0;
    endtask

    task automatic set_pc(input logic [15:0] v);
        idle();
        PCOverwrite = 1; OverwriteAddress = v;
        tick();
        PCOverwrite = 0;
    endtask

    // Reference model: architectural PC, halted flag and pending redirect.
    logic [15:0] m_pc, m_tgt, e_npc;
    bit          m_halted, m_pend, e_fv;
    logic [1:0]  e_sel;

    task automatic model_step();
        bit          red;
        logic [15:0] tgt;
        logic [1:0]  rsel;
        logic [15:0] n_pc, n_tgt;
        bit          n_halt, n_pend;
        red  = PCOverwrite || TakeJump || TakeBranch;
        tgt  = PCOverwrite ? OverwriteAddress : TakeJump ? JumpTarget : BranchTarget;
        rsel = PCOverwrite ? 2'd3 : TakeJump ? 2'd2 : TakeBranch ? 2'd1 : 2'd0;
        n_pc = m_pc; n_tgt = m_tgt; n_halt = m_halted; n_pend = m_pend;
        e_sel = 2'd0;
        e_fv  = !Reset && !m_halted && !Stall;
        if (Reset) begin
            n_pc = 16'h0000; n_halt = 0; n_pend = 0;
        end else if (m_halted) begin
            if (PCOverwrite) begin n_pc = OverwriteAddress; e_sel = 2'd3; n_halt = 0; end
        end else if (Stall && Hold) begin
            e_sel = rsel;
            if (red) begin n_pend = 1; n_tgt = tgt; end
            else if (Halt) begin n_halt = 1; n_pend = 0; end
        end else if (red) begin
            n_pc = tgt; e_sel = rsel; n_pend = 0;
        end else if (Stall) begin
            if (Halt) n_halt = 1;
        end else if (m_pend) begin
            n_pc = m_tgt; e_sel = 2'd3; n_pend = 0;
        end else if (Halt) begin
            n_halt = 1;
        end else begin
            n_pc = 16'((int'(m_pc) + 1) % 65536);
        end
        e_npc = n_pc;
        m_pc = n_pc; m_tgt = n_tgt; m_halted = n_halt; m_pend = n_pend;
    endtask

    task automatic test_reset();
        idle(); Reset = 1;
        tick(); tick();
        n_checks++; if (PC !== 16'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", PC); end
        n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b want 0", FetchValid); end
        n_checks++; if (NextPC !== 16'h0) begin n_fail++; $display("FAIL rst_npc: got %h want 0", NextPC); end
        n_checks++; if (PCSel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", PCSel); end
        n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", Halted); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", RedirectPending); end
        Reset = 0;
        #2;
        n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL run_fv: got %b want 1", FetchValid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (PC !== 16'(i)) begin n_fail++; $display("FAIL idle_pc%0d: got %h want %h", i, PC, 16'(i)); end
            n_checks++; if (PCSel !== 2'd0) begin n_fail++; $display("FAIL idle_sel%0d: got %0d want 0", i, PCSel); end
        end
    endtask

    task automatic test_priority();
        set_pc(16'd5);
        TakeBranch = 1; BranchTarget = 16'd10; TakeJump = 1; JumpTarget = 16'd78;
        #2;
        n_checks++; if (PCSel !== 2'd2) begin n_fail++; $display("FAIL prio_sel: got %0d want 2", PCSel); end
        n_checks++; if (NextPC !== 16'd78) begin n_fail++; $display("FAIL prio_npc: got %h want 004e", NextPC); end
        tick(); idle();
        n_checks++; if (PC !== 16'd78) begin n_fail++; $display("FAIL prio_pc: got %h want 004e", PC); end
        PCOverwrite = 1; OverwriteAddress = 16'h1234; TakeJump = 1; JumpTarget = 16'h0777;
        #2;
        n_checks++; if (PCSel !== 2'd3) begin n_fail++; $display("FAIL ow_sel: got %0d want 3", PCSel); end
        tick(); idle();
        n_checks++; if (PC !== 16'h1234) begin n_fail++; $display("FAIL ow_pc: got %h want 1234", PC); end
        TakeBranch = 1; BranchTarget = 16'h0200; Halt = 1;
        tick(); idle();
        n_checks++; if (PC !== 16'h0200) begin n_fail++; $display("FAIL brhalt_pc: got %h want 0200", PC); end
        n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL brhalt_halted: got %b want 0", Halted); end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFF);
        tick();
        n_checks++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", PC); end
    endtask

    task automatic test_stall();
        set_pc(16'd40);
        Stall = 1;
        #2;
        n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL stall_fv: got %b want 0", FetchValid); end
        tick();
        n_checks++; if (PC !== 16'd40) begin n_fail++; $display("FAIL stall_pc1: got %h want 0028", PC); end
        TakeJump = 1; JumpTarget = 16'd78;
        #2;
        n_checks++; if (PCSel !== 2'd2) begin n_fail++; $display("FAIL stall_sel: got %0d want 2", PCSel); end
        tick(); TakeJump = 0;
`ifdef PC_SEQ_REDIRECT_HOLD_EN
        n_checks++; if (PC !== 16'd40) begin n_fail++; $display("FAIL stall_pc2: got %h want 0028", PC); end
        n_checks++; if (RedirectPending !== 1'b1) begin n_fail++; $display("FAIL stall_pend: got %b want 1", RedirectPending); end
        tick();
        n_checks++; if (PC !== 16'd40) begin n_fail++; $display("FAIL stall_pc3: got %h want 0028", PC); end
        Stall = 0;
        #2;
        n_checks++; if (PCSel !== 2'd3) begin n_fail++; $display("FAIL rel_sel: got %0d want 3", PCSel); end
        tick();
        n_checks++; if (PC !== 16'd78) begin n_fail++; $display("FAIL rel_pc: got %h want 004e", PC); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL rel_pend: got %b want 0", RedirectPending); end
        // Redirect in the release cycle wins and the buffered entry is dropped.
        Stall = 1; TakeJump = 1; JumpTarget = 16'h0300;
        tick();
        Stall = 0; TakeJump = 0; TakeBranch = 1; BranchTarget = 16'd10;
        tick(); idle();
        n_checks++; if (PC !== 16'd10) begin n_fail++; $display("FAIL relbr_pc: got %h want 000a", PC); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL relbr_pend: got %b want 0", RedirectPending); end
        tick();
        n_checks++; if (PC !== 16'd11) begin n_fail++; $display("FAIL relbr_pc2: got %h want 000b", PC); end
        // Halt during a stall clears the buffer.
        Stall = 1; TakeJump = 1; JumpTarget = 16'h0400;
        tick();
        TakeJump = 0; Halt = 1;
        tick(); idle();
        n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL sthalt_halted: got %b want 1", Halted); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL sthalt_pend: got %b want 0", RedirectPending); end
`else
        n_checks++; if (PC !== 16'd78) begin n_fail++; $display("FAIL stall_pc2: got %h want 004e", PC); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL stall_pend: got %b want 0", RedirectPending); end
        tick();
        n_checks++; if (PC !== 16'd78) begin n_fail++; $display("FAIL stall_pc3: got %h want 004e", PC); end
        Stall = 0;
        tick();
        n_checks++; if (PC !== 16'd79) begin n_fail++; $display("FAIL rel_pc: got %h want 004f", PC); end
`endif
        idle();
    endtask

    task automatic test_halt();
        set_pc(16'd20);
        Halt = 1;
        #2;
        n_checks++; if (NextPC !== 16'd20) begin n_fail++; $display("FAIL halt_npc: got %h want 0014", NextPC); end
        tick(); Halt = 0;
        for (int i = 0; i < 4; i++) begin
            TakeBranch = 1; BranchTarget = 16'd10; TakeJump = i[0]; JumpTarget = 16'd99;
            Stall = i[1];
            #2;
            n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL halt_fv%0d: got %b want 0", i, FetchValid); end
            n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag%0d: got %b want 1", i, Halted); end
            tick();
            n_checks++; if (PC !== 16'd20) begin n_fail++; $display("FAIL halt_pc%0d: got %h want 0014", i, PC); end
        end
        idle();
        PCOverwrite = 1; OverwriteAddress = 16'd35;
        #2;
        n_checks++; if (PCSel !== 2'd3) begin n_fail++; $display("FAIL exit_sel: got %0d want 3", PCSel); end
        tick(); idle();
        n_checks++; if (PC !== 16'd35) begin n_fail++; $display("FAIL exit_pc: got %h want 0023", PC); end
        n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL exit_halted: got %b want 0", Halted); end
        tick();
        n_checks++; if (PC !== 16'd36) begin n_fail++; $display("FAIL exit_pc2: got %h want 0024", PC); end
    endtask

    task automatic test_reset_midway();
        set_pc(16'd50);
        Stall = 1; TakeJump = 1; JumpTarget = 16'd78;
        tick(); idle();
        Reset = 1;
        #2;
        n_checks++; if (NextPC !== 16'h0) begin n_fail++; $display("FAIL mrst_npc: got %h want 0", NextPC); end
        n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL mrst_fv: got %b want 0", FetchValid); end
        tick(); Reset = 0;
        n_checks++; if (PC !== 16'h0) begin n_fail++; $display("FAIL mrst_pc: got %h want 0", PC); end
        n_checks++; if (RedirectPending !== 1'b0) begin n_fail++; $display("FAIL mrst_pend: got %b want 0", RedirectPending); end
        set_pc(16'd60); Halt = 1;
        tick(); Halt = 0; Reset = 1;
        tick(); Reset = 0;
        n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL mrst_halted: got %b want 0", Halted); end
        tick();
        n_checks++; if (PC !== 16'h1) begin n_fail++; $display("FAIL mrst_pc2: got %h want 0001", PC); end
    endtask

    task automatic test_random();
        idle(); Reset = 1;
        tick(); Reset = 0;
        m_pc = 16'h0; m_tgt = 16'h0; m_halted = 0; m_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(99) == 0);
            Stall       = ($urandom_range(3) == 0);
            PCOverwrite = ($urandom_range(9) == 0);
            TakeJump    = ($urandom_range(6) == 0);
            TakeBranch  = ($urandom_range(6) == 0);
            // Halt only without a redirect so the stall/halt/redirect overlap stays well defined.
            Halt = !(PCOverwrite || TakeJump || TakeBranch) && ($urandom_range(12) == 0);
            BranchTarget     = 16'($urandom);
            JumpTarget       = 16'($urandom);
            OverwriteAddress = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            model_step();
            #2;
            n_checks++; if (NextPC !== e_npc) begin n_fail++; $display("FAIL rnd_npc @%0d: got %h want %h", i, NextPC, e_npc); end
            n_checks++; if (PCSel !== e_sel) begin n_fail++; $display("FAIL rnd_sel @%0d: got %0d want %0d", i, PCSel, e_sel); end
            n_checks++; if (FetchValid !== e_fv) begin n_fail++; $display("FAIL rnd_fv @%0d: got %b want %b", i, FetchValid, e_fv); end
            tick();
            n_checks++; if (PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc @%0d: got %h want %h", i, PC, m_pc); end
            n_checks++; if (Halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted @%0d: got %b want %b", i, Halted, m_halted); end
            n_checks++; if (RedirectPending !== m_pend) begin n_fail++; $display("FAIL rnd_pend @%0d: got %b want %b", i, RedirectPending, m_pend); end
        end
        idle(); Reset = 0;
    endtask

    initial begin
        BranchTarget = '0; JumpTarget = '0; OverwriteAddress = '0;
        idle(); Reset = 1;
        test_reset();
        test_priority();
        test_wrap();
        test_stall();
        test_halt();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
